data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Word-organised data memory with a fixed-latency read-modify-write path for
// byte/halfword/word stores and a one-cycle registered read that tracks address.
//
// state | meaning
// IDLE  | tracking reads; a non-zero write is accepted and latched
// RD    | latched word is read into the merge register
// WR    | merged word is written back
// DONE  | acknowledge held until write returns to 00
module data_mem_responder #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [1:0]  write,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        error,
    output logic        done
);

    localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     mem [DEPTH];
    logic [31:0]     mem_word;
    logic [31:0]     rd_val;
    logic [31:0]     merge;
    logic [31:0]     merged;
    logic [AW+1:0]   lat_addr;
    logic [1:0]      lat_size;
    logic [31:0]     lat_wdata;
    logic [AW-1:0]   rd_idx;
    logic            in_range;
    logic            misaligned;
    logic            accept;
    logic            mem_we;

    assign in_range   = {1'b0, address} < LIMIT;
    assign misaligned = !in_range
                      || (write == 2'b10 && address[0])
                      || (write == 2'b11 && address[1:0] != 2'b00);
    assign accept     = (state == IDLE) && (write != 2'b00);
    assign mem_we     = rst && (state == WR);

    // One read port: RD fetches the latched word, every other state follows address.
    assign rd_idx   = (state == RD) ? lat_addr[AW+1:2] : address[AW+1:2];
    assign mem_word = mem[rd_idx];
    assign rd_val   = in_range ? (mem_word >> {address[1:0], 3'b000}) : 32'h0;

    always_comb begin
        merged = merge;
        case (lat_size)
            2'b01:   merged[{lat_addr[1:0], 3'b000} +: 8]  = lat_wdata[7:0];
            2'b10:   merged[{lat_addr[1], 4'b0000} +: 16]  = lat_wdata[15:0];
            2'b11:   merged = lat_wdata;
            default: merged = merge;
        endcase
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (write == 2'b00) state_nxt = IDLE;
                else if (misaligned) state_nxt = DONE;
                else state_nxt = RD;
            end
            RD:   state_nxt = WR;
            WR:   state_nxt = DONE;
            DONE: state_nxt = (done && write == 2'b00) ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Storage is never reset; a write aborted by reset simply never happens.
    always_ff @(posedge clk) begin
        if (mem_we) mem[lat_addr[AW+1:2]] <= merged;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr  <= address[AW+1:0];
            lat_size  <= write;
            lat_wdata <= wdata;
        end
        if (state == RD) merge <= mem_word;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= 32'h0;
            error <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rdata <= rd_val;
                    if (write == 2'b00) error <= !in_range;
                    else if (misaligned) error <= 1'b1;
                end
                WR: begin
                    error <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    rdata <= rd_val;
                    // A misaligned request enters DONE without done set; raise it first.
                    if (!done) done <= 1'b1;
                    else if (write == 2'b00) done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
